wash_setup_ctrl: RTL and testbench
==================================

// Module: wash_setup_ctrl
// PURPOSE
//  Parametrised pre-wash setup controller, second generation of the washer front-end.
//  Sequences four phases:
//   - balance entry: BCD digits set by slide switches, with sign rejection;
//   - mode select;
//   - load-weight entry with lid interlock;
//   - a cost check against the balance before issuing a single start pulse.
//  Sits between the button debouncers / switches and the wash sequencer. Drives BCD digits to the scan4 display drivers.
// PARAMETERS
//  NDIG      3           balance digits (BCD), 1..4
//  NMODES    4           number of wash modes, 2..8
//  MAX_WGT   20          max load weight in kg; weight range 0..MAX_WGT
//  TICK_DIV  66_000_000  clk cycles per switch auto-increment tick
//  IDLE_TO   1_000_000_000  clk cycles without a key press before MODE/WGT abort
//  PRICE_TBL {8'd4,8'd3,8'd2,8'd1}  packed NMODES x 8b price per kg; mode m = PRICE_TBL[8m+:8]
// PORTS
//  clk       in   1            system clock
//  rst       in   1            asynchronous active-low reset
//  on        in   1            power enable; 0 freezes all state (no counting, keys ignored)
//  dig_sw    in   NDIG         digit switches, bit0 = units
//  sign_sw   in   1            sign switch
//  r_pls,m_pls,u_pls,d_pls in 1  debounced 1-cycle key pulses (right/confirm/up/down)
//  lid_open  in   1            1 = lid open
//  wash_done in   1            1-cycle pulse from sequencer, end of wash
//  disp_bcd  out  4*NDIG       BCD digits for display; 4'hB = blank
//  disp_neg  out  1            minus-sign indicator
//  st_light  out  4            one-hot phase: BAL=0001 MODE=0010 WGT=0100 RUN=1000
//  mode      out  3            latched mode
//  weight    out  5            current/latched weight, kg
//  bal       out  BW           binary balance, BW = $clog2(10**NDIG)
//  start     out  1            1-cycle start pulse
//  err       out  1            rejected confirm; held until next key pulse
// BEHAVIOUR
//  Reset
//   - S_BAL; digits 0; neg=0; bal=0; mode=0; weight=0; start=0; err=0.
//   - Tick and idle counters 0.
//  S_BAL
//   - Tick counter wraps at TICK_DIV-1.
//   - On wrap, each digit i with dig_sw[i]=1 steps +1 mod 10.
//   - On wrap with sign_sw=1, neg toggles.
//   - m_pls with dig_sw==0, sign_sw=0, neg=0: bal <= binary(BCD) (mult-by-10 chain, combinational); digits cleared; go S_MODE.
//   - m_pls otherwise: digits and neg cleared; err=1; stay in S_BAL.
//  S_MODE
//   - disp shows mode in digit0; other digits blank.
//   - r_pls: mode+1 mod NMODES. d_pls: mode-1 mod NMODES.
//   - u_pls: go S_WGT; weight=0.
//  S_WGT
//   - disp shows weight in decimal.
//   - r_pls: weight+1, or +10 when dig_sw[0]=1. Saturates at MAX_WGT.
//   - d_pls: weight-1, saturates at 0.
//   - m_pls: cost = weight*price(mode), computed at full width.
//     - Accept when lid_open=0, weight!=0 and cost<=bal: next cycle start=1, bal <= bal-cost, go S_RUN.
//     - Otherwise err=1 and stay.
//  S_RUN
//   - All keys ignored.
//   - wash_done: go S_MODE, bal retained.
//   - If bal==0 on wash_done: go S_BAL instead.
//  Idle timeout
//   - In S_MODE/S_WGT the idle counter clears on any key pulse.
//   - At IDLE_TO it returns to S_BAL with bal preserved, err=0.
//  Simultaneous events
//   - Priority m > u > r > d; one action per cycle.
//   - A tick wrap and m_pls in the same cycle: confirm uses the pre-increment digits.
//  err clears on the cycle after any key pulse, unless that pulse re-errors.
//  Reset mid-operation (any state): immediate return to reset values; no start pulse.
//  on=0: counters, FSM and outputs hold; start is forced 0.
// STRUCTURE
//  Shared package wash_pkg:
//   - state enum S_BAL/S_MODE/S_WGT/S_RUN;
//   - BLANK=4'hB;
//   - st_light encodings.
//  One sub-module: wash_bcd2bin (NDIG BCD -> BW binary, combinational).
//  Binary-to-BCD of weight (<=31) done inline.
// TESTING
//  1. Reset, dig_sw=3'b011 for 3 ticks, release, m_pls -> bal=33, S_MODE, st_light=0010.
//  2. S_BAL, sign_sw=1 for 1 tick, release, m_pls -> err=1, digits 0, stay S_BAL, bal=0.
//  3. bal=33, mode=1 (price 2), weight=12, lid_open=0, m_pls -> start high 1 cycle, bal=9, S_RUN.
//  4. Same setup with lid_open=1 or weight=17 (cost 34 > 33), m_pls -> err=1, no start, stay S_WGT.
//  5. S_WGT weight=19, dig_sw[0]=1, r_pls -> weight=20; d_pls x25 -> weight=0; S_MODE mode=3, r_pls -> mode=0.
//  6. rst low mid-S_RUN -> reset values; no key for IDLE_TO in S_MODE -> S_BAL, bal unchanged.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types and constants for the washer pre-wash setup controller.
package wash_pkg;

    typedef enum logic [1:0] {
        S_BAL  = 2'd0,
        S_MODE = 2'd1,
        S_WGT  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic [3:0] BLANK      = 4'hB;

    localparam logic [3:0] LIGHT_BAL  = 4'b0001;
    localparam logic [3:0] LIGHT_MODE = 4'b0010;
    localparam logic [3:0] LIGHT_WGT  = 4'b0100;
    localparam logic [3:0] LIGHT_RUN  = 4'b1000;

    function automatic logic [3:0] state_light(input state_t s);
        case (s)
            S_BAL:   return LIGHT_BAL;
            S_MODE:  return LIGHT_MODE;
            S_WGT:   return LIGHT_WGT;
            default: return LIGHT_RUN;
        endcase
    endfunction

endpackage

// File: rtl/wash_bcd2bin.sv
// Combinational BCD to binary conversion, most significant digit first.
module wash_bcd2bin #(
    parameter int NDIG = 3,
    parameter int BW   = $clog2(10**NDIG)
) (
    input  logic [4*NDIG-1:0] bcd,
    output logic [BW-1:0]     bin
);

    logic [BW-1:0] acc;

    // Multiply-by-ten accumulate chain across the digits
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            acc = BW'(acc * BW'(10)) + BW'(bcd[4*(NDIG-1-k) +: 4]);
        end
        bin = acc;
    end

endmodule

// File: rtl/wash_setup_ctrl.sv
// Pre-wash setup controller: balance entry, mode select, weight entry,
// cost check and a single start pulse towards the wash sequencer.
module wash_setup_ctrl
    import wash_pkg::*;
#(
    parameter int                     NDIG      = 3,
    parameter int                     NMODES    = 4,
    parameter int                     MAX_WGT   = 20,
    parameter int unsigned            TICK_DIV  = 66_000_000,
    parameter int unsigned            IDLE_TO   = 1_000_000_000,
    parameter logic [8*NMODES-1:0]    PRICE_TBL = {8'd4, 8'd3, 8'd2, 8'd1},
    localparam int                    BW        = $clog2(10**NDIG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              on,
    input  logic [NDIG-1:0]   dig_sw,
    input  logic              sign_sw,
    input  logic              r_pls,
    input  logic              m_pls,
    input  logic              u_pls,
    input  logic              d_pls,
    input  logic              lid_open,
    input  logic              wash_done,
    output logic [4*NDIG-1:0] disp_bcd,
    output logic              disp_neg,
    output logic [3:0]        st_light,
    output logic [2:0]        mode,
    output logic [4:0]        weight,
    output logic [BW-1:0]     bal,
    output logic              start,
    output logic              err
);

    localparam int CW = (BW > 13) ? BW + 1 : 14;

    state_t            state, state_d;
    logic [4*NDIG-1:0] dig, dig_d;
    logic              neg, neg_d;
    logic [BW-1:0]     bal_d, bal_bin;
    logic [2:0]        mode_d;
    logic [4:0]        weight_d;
    logic              err_d, start_q, start_d;
    logic [31:0]       tick, tick_d, idle, idle_d;
    logic              any_key, tick_wrap, idle_expired, accept;
    logic [7:0]        price;
    logic [CW-1:0]     cost, bal_w;
    logic [5:0]        wsum;
    logic [3:0]        w_tens, w_units;

    wash_bcd2bin #(.NDIG(NDIG), .BW(BW)) u_bcd2bin (
        .bcd (dig),
        .bin (bal_bin)
    );

    assign any_key      = r_pls | m_pls | u_pls | d_pls;
    assign tick_wrap    = (tick == 32'(TICK_DIV - 1));
    assign idle_expired = !any_key && (idle == 32'(IDLE_TO - 1));
    assign price        = PRICE_TBL[8*mode +: 8];
    assign cost         = CW'(weight) * CW'(price);
    assign bal_w        = CW'(bal);
    assign accept       = !lid_open && (weight != 5'd0) && (cost <= bal_w);
    assign wsum         = 6'(weight) + (dig_sw[0] ? 6'd10 : 6'd1);

    // Next-state and next-datapath values; on=0 holds everything
    always_comb begin
        state_d  = state;
        dig_d    = dig;
        neg_d    = neg;
        bal_d    = bal;
        mode_d   = mode;
        weight_d = weight;
        err_d    = err;
        start_d  = 1'b0;
        tick_d   = tick;
        idle_d   = idle;
        if (on) begin
            if (any_key) err_d = 1'b0;
            case (state)
                S_BAL: begin
                    idle_d = '0;
                    tick_d = tick_wrap ? '0 : tick + 32'd1;
                    // Confirm samples the registered digits, so a coincident tick never counts
                    if (m_pls) begin
                        dig_d = '0;
                        if (dig_sw == '0 && !sign_sw && !neg) begin
                            bal_d   = bal_bin;
                            state_d = S_MODE;
                            tick_d  = '0;
                        end else begin
                            neg_d = 1'b0;
                            err_d = 1'b1;
                        end
                    end else if (tick_wrap) begin
                        for (int unsigned i = 0; i < NDIG; i++) begin
                            if (dig_sw[i]) begin
                                dig_d[4*i +: 4] = (dig[4*i +: 4] == 4'd9) ? 4'd0 : dig[4*i +: 4] + 4'd1;
                            end
                        end
                        if (sign_sw) neg_d = ~neg;
                    end
                end
                S_MODE: begin
                    tick_d = '0;
                    idle_d = any_key ? '0 : idle + 32'd1;
                    if (!m_pls) begin
                        if (u_pls) begin
                            state_d  = S_WGT;
                            weight_d = '0;
                        end else if (r_pls) begin
                            mode_d = (mode == 3'(NMODES - 1)) ? 3'd0 : mode + 3'd1;
                        end else if (d_pls) begin
                            mode_d = (mode == 3'd0) ? 3'(NMODES - 1) : mode - 3'd1;
                        end
                    end
                    if (idle_expired) begin
                        state_d = S_BAL;
                        idle_d  = '0;
                        err_d   = 1'b0;
                    end
                end
                S_WGT: begin
                    tick_d = '0;
                    idle_d = any_key ? '0 : idle + 32'd1;
                    if (m_pls) begin
                        if (accept) begin
                            start_d = 1'b1;
                            bal_d   = BW'(bal_w - cost);
                            state_d = S_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (!u_pls) begin
                        if (r_pls) begin
                            weight_d = (wsum > 6'(MAX_WGT)) ? 5'(MAX_WGT) : wsum[4:0];
                        end else if (d_pls) begin
                            weight_d = (weight == 5'd0) ? 5'd0 : weight - 5'd1;
                        end
                    end
                    if (idle_expired) begin
                        state_d = S_BAL;
                        idle_d  = '0;
                        err_d   = 1'b0;
                    end
                end
                default: begin
                    tick_d = '0;
                    idle_d = '0;
                    if (wash_done) state_d = (bal == '0) ? S_BAL : S_MODE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_BAL;
            dig     <= '0;
            neg     <= 1'b0;
            bal     <= '0;
            mode    <= '0;
            weight  <= '0;
            err     <= 1'b0;
            start_q <= 1'b0;
            tick    <= '0;
            idle    <= '0;
        end else begin
            state   <= state_d;
            dig     <= dig_d;
            neg     <= neg_d;
            bal     <= bal_d;
            mode    <= mode_d;
            weight  <= weight_d;
            err     <= err_d;
            start_q <= start_d;
            tick    <= tick_d;
            idle    <= idle_d;
        end
    end

    // Weight (0..31) split into tens and units
    always_comb begin
        w_tens  = 4'd0;
        w_units = 4'(weight);
        if (weight >= 5'd30) begin
            w_tens  = 4'd3;
            w_units = 4'(weight - 5'd30);
        end else if (weight >= 5'd20) begin
            w_tens  = 4'd2;
            w_units = 4'(weight - 5'd20);
        end else if (weight >= 5'd10) begin
            w_tens  = 4'd1;
            w_units = 4'(weight - 5'd10);
        end
    end

    // Display digit selection per phase
    always_comb begin
        disp_bcd = dig;
        if (state != S_BAL) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                disp_bcd[4*i +: 4] = BLANK;
            end
            if (state == S_MODE) begin
                disp_bcd[3:0] = {1'b0, mode};
            end else begin
                disp_bcd[3:0] = w_units;
                if (NDIG > 1) disp_bcd[4*(NDIG > 1 ? 1 : 0) +: 4] = w_tens;
            end
        end
    end

    assign disp_neg = neg;
    assign st_light = state_light(state);
    assign start    = start_q & on;

endmodule

// File: tb/tb_wash_setup_ctrl.sv
// Directed bench for wash_setup_ctrl with short tick and idle periods.
module tb_wash_setup_ctrl;

    localparam int NDIG    = 3;
    localparam int BW      = 10;
    localparam int IDLE_TO = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              on;
    logic [NDIG-1:0]   dig_sw;
    logic              sign_sw, r_pls, m_pls, u_pls, d_pls, lid_open, wash_done;
    logic [4*NDIG-1:0] disp_bcd;
    logic              disp_neg, start, err;
    logic [3:0]        st_light;
    logic [2:0]        mode;
    logic [4:0]        weight;
    logic [BW-1:0]     bal;

    int errors = 0;
    int checks = 0;

    wash_setup_ctrl #(
        .NDIG     (NDIG),
        .NMODES   (4),
        .MAX_WGT  (20),
        .TICK_DIV (4),
        .IDLE_TO  (IDLE_TO),
        .PRICE_TBL({8'd4, 8'd3, 8'd2, 8'd1})
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .on        (on),
        .dig_sw    (dig_sw),
        .sign_sw   (sign_sw),
        .r_pls     (r_pls),
        .m_pls     (m_pls),
        .u_pls     (u_pls),
        .d_pls     (d_pls),
        .lid_open  (lid_open),
        .wash_done (wash_done),
        .disp_bcd  (disp_bcd),
        .disp_neg  (disp_neg),
        .st_light  (st_light),
        .mode      (mode),
        .weight    (weight),
        .bal       (bal),
        .start     (start),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0=m 1=u 2=r 3=d
    task automatic key(input int which);
        case (which)
            0: m_pls = 1'b1;
            1: u_pls = 1'b1;
            2: r_pls = 1'b1;
            default: d_pls = 1'b1;
        endcase
        step();
        m_pls = 1'b0; u_pls = 1'b0; r_pls = 1'b0; d_pls = 1'b0;
    endtask

    initial begin
        rst = 1'b0; on = 1'b1; dig_sw = '0; sign_sw = 1'b0;
        r_pls = 1'b0; m_pls = 1'b0; u_pls = 1'b0; d_pls = 1'b0;
        lid_open = 1'b0; wash_done = 1'b0;
        #13;
        check("rst_light", st_light, 4'b0001);
        check("rst_bal", bal, 0);
        check("rst_mode", mode, 0);
        check("rst_weight", weight, 0);
        check("rst_start", start, 0);
        check("rst_err", err, 0);
        check("rst_disp", disp_bcd, 0);
        check("rst_neg", disp_neg, 0);
        rst = 1'b1;
        step();

        // sign set then confirm is rejected
        sign_sw = 1'b1;
        repeat (4) step();
        sign_sw = 1'b0;
        check("neg_toggle", disp_neg, 1);
        key(0);
        check("neg_rej_err", err, 1);
        check("neg_rej_light", st_light, 4'b0001);
        check("neg_rej_disp", disp_bcd, 0);
        check("neg_rej_neg", disp_neg, 0);
        check("neg_rej_bal", bal, 0);

        // balance 033 via three ticks
        dig_sw = 3'b011;
        repeat (12) step();
        dig_sw = '0;
        check("bal_digits", disp_bcd, 12'h033);
        check("err_held", err, 1);
        key(0);
        check("bal_33", bal, 33);
        check("bal_light", st_light, 4'b0010);
        check("bal_err_clr", err, 0);
        check("mode_disp", disp_bcd, 12'hBB0);

        // power off freezes keys
        on = 1'b0;
        key(2);
        check("off_mode", mode, 0);
        on = 1'b1;

        // mode 1, weight 12
        key(2);
        check("mode_1", mode, 1);
        key(1);
        check("wgt_light", st_light, 4'b0100);
        check("wgt_zero", weight, 0);
        dig_sw = 3'b001;
        key(2);
        dig_sw = '0;
        key(2);
        key(2);
        check("wgt_12", weight, 12);
        check("wgt_disp", disp_bcd, 12'hB12);

        // lid open and over-cost rejections
        lid_open = 1'b1;
        key(0);
        check("lid_err", err, 1);
        check("lid_light", st_light, 4'b0100);
        check("lid_start", start, 0);
        lid_open = 1'b0;
        repeat (5) key(2);
        check("wgt_17", weight, 17);
        key(0);
        check("cost_err", err, 1);
        check("cost_light", st_light, 4'b0100);
        check("cost_start", start, 0);
        repeat (5) key(3);
        check("wgt_back12", weight, 12);
        check("err_clr_d", err, 0);

        // accepted start
        key(0);
        check("start_hi", start, 1);
        check("bal_9", bal, 9);
        check("run_light", st_light, 4'b1000);
        step();
        check("start_lo", start, 0);
        key(2);
        check("run_ign_w", weight, 12);
        check("run_ign_m", mode, 1);
        wash_done = 1'b1;
        step();
        wash_done = 1'b0;
        check("done_mode", st_light, 4'b0010);
        check("done_bal", bal, 9);

        // mode wrap both ways
        key(3);
        key(3);
        check("mode_wrap_dn", mode, 3);
        key(2);
        check("mode_wrap_up", mode, 0);

        // weight saturation
        key(1);
        dig_sw = 3'b001;
        key(2);
        dig_sw = '0;
        repeat (9) key(2);
        check("wgt_19", weight, 19);
        dig_sw = 3'b001;
        key(2);
        dig_sw = '0;
        check("wgt_sat10", weight, 20);
        key(2);
        check("wgt_sat1", weight, 20);
        repeat (25) key(3);
        check("wgt_sat0", weight, 0);
        key(0);
        check("wgt0_err", err, 1);
        key(2);
        key(0);
        check("bal_8", bal, 8);
        check("start_2", start, 1);
        wash_done = 1'b1;
        step();
        wash_done = 1'b0;

        // idle timeout in mode select
        repeat (IDLE_TO - 1) step();
        check("idle_before", st_light, 4'b0010);
        step();
        check("idle_light", st_light, 4'b0001);
        check("idle_bal", bal, 8);
        check("idle_err", err, 0);

        // reset in the middle of a run, with the start pulse in flight
        dig_sw = 3'b001;
        repeat (8) step();
        dig_sw = '0;
        key(0);
        check("bal_2", bal, 2);
        key(1);
        key(2);
        key(0);
        check("run2_light", st_light, 4'b1000);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_light", st_light, 4'b0001);
        check("mid_rst_bal", bal, 0);
        check("mid_rst_start", start, 0);
        check("mid_rst_wgt", weight, 0);
        check("mid_rst_disp", disp_bcd, 0);
        #2 rst = 1'b1;
        step();

        // digit wraps 9->0, then a run ending at zero balance
        dig_sw = 3'b001;
        repeat (44) step();
        dig_sw = '0;
        check("dig_wrap", disp_bcd, 12'h001);
        key(0);
        key(1);
        key(2);
        key(0);
        check("bal_0", bal, 0);
        wash_done = 1'b1;
        step();
        wash_done = 1'b0;
        check("zero_bal_light", st_light, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
